serial_frame_rx: RTL and testbench

Synchronous serial-to-parallel frame receiver sitting directly downstream of the DFF_PP0 input-capture flop: it consumes the registered serial bit stream on that flop's Q and assembles start/data/stop frames into parallel words. One bit per clock, no oversampling. Built so it maps cleanly onto the NAND-only flow: the register bits map to the team's flop cells, and the next-state logic is plain combinational gates.

---
 rtl/serial_frame_rx_pkg.sv | 19 +
 rtl/sipo_shift.sv | 34 +++
 rtl/serial_frame_rx.sv | 128 ++++++++++++
 tb/tb_serial_frame_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_rx_pkg.sv
// ----------------------------------------------------------------------------
// serial_frame_rx_pkg
// Shared constants for the serial frame receiver: the FSM state encoding and
// the default frame data width.
// ----------------------------------------------------------------------------
package serial_frame_rx_pkg;

    // Data bits per frame unless the instantiating design overrides it
    localparam int WIDTH_DEFAULT = 8;

    // Receiver states; the fourth encoding (2'b11) is never entered on purpose
    // and the next-state logic sends it back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        STOP = 2'b10
    } state_t;

endpackage

// File: rtl/sipo_shift.sv
// ----------------------------------------------------------------------------
// sipo_shift
// WIDTH-bit serial-in / parallel-out right-shift register. Each enabled edge
// pushes din in at the MSB and moves everything one place toward the LSB, so
// after WIDTH shifts the first bit received sits at bit 0.
//
// Ports:
//   clk      rising-edge clock
//   clr_n    synchronous active-low clear (wins over shift_en)
//   shift_en shift one position on this edge
//   din      serial input bit
//   q        parallel register contents
// ----------------------------------------------------------------------------
module sipo_shift
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// ----------------------------------------------------------------------------
// serial_frame_rx
// One-bit-per-clock frame receiver fed from the registered serial line of the
// upstream DFF_PP0 capture flop. A frame is a low start bit, WIDTH data bits
// (LSB first) and a high stop bit. Good frames are presented on Q with a
// one-cycle V strobe; a low stop bit gives a one-cycle E strobe and leaves Q
// alone.
//
// Ports:
//   C     rising-edge clock
//   R     synchronous active-low reset
//   D     serial line, idles high
//   Q     last correctly framed word (bit 0 = first data bit)
//   V     word-valid strobe, one cycle
//   E     framing-error strobe, one cycle
//   BUSY  high while a frame is in progress
// ----------------------------------------------------------------------------
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             C,
    input  logic             R,
    input  logic             D,
    output logic [WIDTH-1:0] Q,
    output logic             V,
    output logic             E,
    output logic             BUSY
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_word;

    logic             cnt_clr;
    logic             cnt_inc;
    logic             shift_en;
    logic             word_ok;
    logic             word_bad;

    // Data bits are collected here; reset clears it so a frame aborted by
    // reset leaves nothing behind.
    sipo_shift #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk      (C),
        .clr_n    (R),
        .shift_en (shift_en),
        .din      (D),
        .q        (shift_word)
    );

    // State register
    always_ff @(posedge C) begin
        if (!R) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the DATA state leaves on the edge that samples the bit
    // while the counter already holds WIDTH-1, i.e. after WIDTH data edges.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = D ? IDLE : DATA;
            DATA:    state_next = (bit_cnt == LAST_BIT) ? STOP : DATA;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath control decoded from the current state. The counter
    // stops at WIDTH-1 instead of wrapping; leaving DATA ends the count.
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        shift_en = 1'b0;
        word_ok  = 1'b0;
        word_bad = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = !D;
            end
            DATA: begin
                shift_en = 1'b1;
                cnt_inc  = (bit_cnt != LAST_BIT);
            end
            STOP: begin
                word_ok  = D;
                word_bad = !D;
            end
            default: begin
            end
        endcase
    end

    assign BUSY = (state != IDLE);

    // Bit counter and registered outputs. V/E are strobes that live for the
    // single cycle following the stop-bit edge; Q only moves on a good frame.
    always_ff @(posedge C) begin
        if (!R) begin
            bit_cnt <= '0;
            Q       <= '0;
            V       <= 1'b0;
            E       <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (cnt_inc) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            V <= word_ok;
            E <= word_bad;
            if (word_ok) begin
                Q <= shift_word;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_serial_frame_rx
// Drives frames into serial_frame_rx (WIDTH=8) and a second WIDTH=4 instance.
// The frame sender records what each frame must produce; a negedge monitor
// matches every V/E strobe against those records.
// ----------------------------------------------------------------------------
module tb_serial_frame_rx;

    typedef struct {
        logic       is_err;
        logic [7:0] word;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       R;
    logic       D;
    logic [7:0] Q;
    logic       V;
    logic       E;
    logic       BUSY;

    logic       r4;
    logic       d4;
    logic [3:0] q4;
    logic       v4;
    logic       e4;
    logic       busy4;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic       mon_en   = 1'b0;
    logic       exp_busy = 1'b0;
    logic [7:0] exp_q    = 8'h00;
    exp_t       sb[$];

    serial_frame_rx #(.WIDTH(8)) dut (
        .C    (clk),
        .R    (R),
        .D    (D),
        .Q    (Q),
        .V    (V),
        .E    (E),
        .BUSY (BUSY)
    );

    serial_frame_rx #(.WIDTH(4)) dut4 (
        .C    (clk),
        .R    (r4),
        .D    (d4),
        .Q    (q4),
        .V    (v4),
        .E    (e4),
        .BUSY (busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic sendBit(input logic b);
        D = b;
        @(posedge clk);
        #1;
    endtask

    // One frame: start, 8 data bits LSB first, stop. abort_at >= 0 pulls
    // reset low on that data edge instead, and the frame yields nothing.
    task automatic applyStimulus(input logic [7:0] word, input logic stop_bit,
                                 input int abort_at);
        exp_t x;
        sendBit(1'b0);
        exp_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) begin
                R = 1'b0;
                sendBit(word[i]);
                R        = 1'b1;
                exp_busy = 1'b0;
                exp_q    = 8'h00;
                return;
            end
            sendBit(word[i]);
        end
        sendBit(stop_bit);
        exp_busy = 1'b0;
        x.is_err = !stop_bit;
        x.cyc    = cyc;
        if (stop_bit) begin
            exp_q  = word;
            x.word = word;
        end else begin
            x.word = exp_q;
        end
        sb.push_back(x);
    endtask

    // Monitor: steady-state outputs every cycle, strobes against the queue
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t x;
            checkOutput("busy", BUSY, exp_busy);
            checkOutput("q_now", Q, exp_q);
            checkOutput("v_e_exclusive", V & E, 0);
            if (V || E) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_strobe: got V=%0b E=%0b expected none (cycle %0d)",
                             V, E, cyc);
                end else begin
                    x = sb.pop_front();
                    checkOutput("strobe_kind_E", E, x.is_err);
                    checkOutput("strobe_word", Q, x.word);
                    checkOutput("strobe_cycle", cyc, x.cyc);
                end
            end
        end
    end

    initial begin
        logic       bits4[8];
        logic [7:0] w;
        logic       stop;
        int         abort;

        bits4 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        R  = 1'b0;
        D  = 1'b1;
        r4 = 1'b0;
        d4 = 1'b1;

        sendBit(1'b1);
        mon_en = 1'b1;
        sendBit(1'b1);
        R = 1'b1;
        checkOutput("reset_q", Q, 0);
        checkOutput("reset_v", V, 0);
        checkOutput("reset_e", E, 0);
        repeat (20) sendBit(1'b1);

        applyStimulus(8'hA5, 1'b1, -1);
        repeat (2) sendBit(1'b1);
        applyStimulus(8'h3C, 1'b0, -1);
        applyStimulus(8'h01, 1'b1, -1);
        applyStimulus(8'hFF, 1'b1, -1);
        repeat (2) sendBit(1'b1);
        applyStimulus(8'h55, 1'b1, 3);
        repeat (3) sendBit(1'b1);
        applyStimulus(8'h55, 1'b1, -1);

        for (int k = 0; k < 40; k++) begin
            w     = 8'($urandom_range(0, 255));
            stop  = ($urandom_range(0, 4) != 0);
            abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            applyStimulus(w, stop, abort);
            repeat ($urandom_range(0, 3)) sendBit(1'b1);
        end

        repeat (12) sendBit(1'b1);
        checkOutput("pending_strobes", sb.size(), 0);

        // WIDTH=4 instance: nibble 9, strobe expected only after edge 5
        r4 = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 8; k++) begin
            d4 = bits4[k];
            @(posedge clk);
            #4;
            checkOutput("w4_valid", v4, (k == 5));
            checkOutput("w4_err", e4, 0);
            if (k == 5) checkOutput("w4_word", q4, 4'h9);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
